mrd_st_source: RTL and testbench

//  Output-side streamer of the mixed radix DFT: reads one finished frame of dftpts complex

---
 rtl/mrd_st_source.sv | 104 ++++++++++
 tb/tb_mrd_st_source.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mrd_st_source.sv
// mrd_st_source: streams one finished DFT frame from the result RAM onto a valid/ready port,
// using a credit-checked show-ahead FIFO so downstream backpressure never loses a read return.
module mrd_st_source #(
   parameter int DW       = 18,
   parameter int AW       = 12,
   parameter int RAM_LAT  = 1,
   parameter int FIFO_DEP = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_dftpts,
   input  logic          start_inverse,
   output logic          busy,
   output logic          done,
   output logic          ram_rd_en,
   output logic [AW-1:0] ram_rd_addr,
   input  logic [DW-1:0] ram_rd_real,
   input  logic [DW-1:0] ram_rd_imag,
   output logic          src_valid,
   input  logic          src_ready,
   output logic          src_sop,
   output logic          src_eop,
   output logic [DW-1:0] src_d_real,
   output logic [DW-1:0] src_d_imag,
   output logic [AW-1:0] src_dftpts,
   output logic          src_inverse
);
   localparam int PW = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
   localparam int CW = $clog2(FIFO_DEP + 1);
   localparam int EW = 2 * DW + 2;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;
   logic [AW-1:0] rd_addr;
   logic [EW-1:0] mem [FIFO_DEP];
   logic [EW-1:0] head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, inflight;
   logic [CW:0] used;
   logic [RAM_LAT-1:0] pv, ps, pe;
   logic push, pop, last;
   assign last        = rd_addr == src_dftpts - AW'(1);
   // Reads still travelling through the RAM count as already occupying a FIFO slot.
   assign used        = {1'b0, count} + {1'b0, inflight};
   assign ram_rd_en   = state == RUN && used < (CW+1)'(FIFO_DEP);
   assign ram_rd_addr = rd_addr;
   assign push        = pv[RAM_LAT-1];
   assign src_valid   = count != '0;
   assign pop         = src_valid && src_ready;
   assign head        = mem[rd_ptr];
   assign src_sop     = src_valid & head[EW-1];
   assign src_eop     = src_valid & head[EW-2];
   assign src_d_real  = src_valid ? head[2*DW-1:DW] : '0;
   assign src_d_imag  = src_valid ? head[DW-1:0] : '0;
   assign busy        = state != IDLE;
   assign done        = state == DONE;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {ps[RAM_LAT-1], pe[RAM_LAT-1], ram_rd_real, ram_rd_imag};
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rd_addr     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         inflight    <= '0;
         pv          <= '0;
         ps          <= '0;
         pe          <= '0;
         src_dftpts  <= '0;
         src_inverse <= 1'b0;
      end else begin
         pv[0] <= ram_rd_en;
         ps[0] <= rd_addr == '0;
         pe[0] <= last;
         for (int k = 1; k < RAM_LAT; k++) begin
            pv[k] <= pv[k-1];
            ps[k] <= ps[k-1];
            pe[k] <= pe[k-1];
         end
         inflight <= inflight + CW'(ram_rd_en) - CW'(push);
         count    <= count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEP-1) ? '0 : wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEP-1) ? '0 : rd_ptr + PW'(1);
         case (state)
            IDLE:
               if (start && start_dftpts != '0) begin
                  state       <= RUN;
                  rd_addr     <= '0;
                  src_dftpts  <= start_dftpts;
                  src_inverse <= start_inverse;
               end
            RUN:
               if (ram_rd_en) begin
                  if (last) state <= DRAIN;
                  else rd_addr <= rd_addr + AW'(1);
               end
            // The eop pop empties the FIFO: every earlier read has already been delivered.
            DRAIN:   if (pop && src_eop) state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mrd_st_source.sv
// tb_mrd_st_source: directed frames against a modelled result RAM returning addr / addr^KEY.
module tb_mrd_st_source;
   localparam int DW = 18, AW = 12, RAM_LAT = 1, FIFO_DEP = 4;
   localparam logic [DW-1:0] KEY = 18'h2A5A5;
   logic clk, rst, start, start_inverse, busy, done, ram_rd_en;
   logic [AW-1:0] start_dftpts, ram_rd_addr, src_dftpts;
   logic [DW-1:0] ram_rd_real, ram_rd_imag, src_d_real, src_d_imag;
   logic src_valid, src_ready, src_sop, src_eop, src_inverse;
   logic [DW-1:0] pr [RAM_LAT];
   logic [DW-1:0] pim [RAM_LAT];
   int checks = 0, failures = 0, maxc = 0;

   mrd_st_source #(.DW(DW), .AW(AW), .RAM_LAT(RAM_LAT), .FIFO_DEP(FIFO_DEP)) dut (
      .clk(clk), .rst(rst), .start(start), .start_dftpts(start_dftpts),
      .start_inverse(start_inverse), .busy(busy), .done(done), .ram_rd_en(ram_rd_en),
      .ram_rd_addr(ram_rd_addr), .ram_rd_real(ram_rd_real), .ram_rd_imag(ram_rd_imag),
      .src_valid(src_valid), .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
      .src_d_real(src_d_real), .src_d_imag(src_d_imag), .src_dftpts(src_dftpts),
      .src_inverse(src_inverse));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      pr[0]  <= ram_rd_en ? DW'(ram_rd_addr) : '1;
      pim[0] <= ram_rd_en ? DW'(ram_rd_addr) ^ KEY : '1;
      for (int k = 1; k < RAM_LAT; k++) begin
         pr[k]  <= pr[k-1];
         pim[k] <= pim[k-1];
      end
   end
   assign ram_rd_real = pr[RAM_LAT-1];
   assign ram_rd_imag = pim[RAM_LAT-1];

   always @(negedge clk)
      if (int'(dut.count) + int'(dut.inflight) > maxc) maxc = int'(dut.count) + int'(dut.inflight);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {busy, done, ram_rd_en, src_valid, src_sop, src_eop, src_inverse}, 0);
      chk({tag, "_addr"}, ram_rd_addr, 0);
      chk({tag, "_dftpts"}, src_dftpts, 0);
      chk({tag, "_real"}, src_d_real, 0);
      chk({tag, "_imag"}, src_d_imag, 0);
   endtask

   // mode 0: ready high; 1: ready random; 2: ready high except a 20-cycle stall after stall_at beats
   task automatic run_frame(input int n, input bit inv, input int mode, input int stall_at,
                            input int rogue_step, input int rst_at);
      int idx, stall;
      bit seen, fin, stalled;
      logic [DW-1:0] hr, hi;
      idx = 0; stall = 0; seen = 0; fin = 0; stalled = 0; hr = '0; hi = '0;
      @(negedge clk);
      start = 1'b1; start_dftpts = AW'(n); start_inverse = inv; src_ready = 1'b1;
      for (int step = 1; step < n * 8 + 100 && !fin; step++) begin
         @(negedge clk);
         start = step == rogue_step;
         start_dftpts = step == rogue_step ? AW'(7) : AW'(n);
         start_inverse = step == rogue_step ? !inv : inv;
         if (step == 1) begin
            chk("rd_en_t1", ram_rd_en, 1);
            chk("addr_t1", ram_rd_addr, 0);
            chk("busy_t1", busy, 1);
            chk("dftpts_latch", src_dftpts, n);
            chk("inverse_latch", src_inverse, inv);
         end
         chk("done_early", done, 0);
         if (src_valid && !seen) begin
            seen = 1;
            chk("first_valid_step", step, 2 + RAM_LAT);
         end else if (seen && mode != 1) chk("no_gap", src_valid, 1);
         if (rst_at >= 0 && idx == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk_zero("mid_reset");
            chk("mid_reset_cnt", dut.count, 0);
            repeat (6) begin
               @(negedge clk);
               chk("post_reset_idle", {busy, done, src_valid, ram_rd_en}, 0);
            end
            return;
         end
         if (mode == 2 && !stalled && stall == 0 && idx == stall_at && src_valid) begin
            stall = 20; hr = src_d_real; hi = src_d_imag;
         end
         if (stall > 0) begin
            chk("stall_real", src_d_real, hr);
            chk("stall_imag", src_d_imag, hi);
            chk("stall_valid", src_valid, 1);
            if (stall == 1) chk("credit_stop", ram_rd_en, 0);
            stall--;
            stalled = stall == 0;
            src_ready = 1'b0;
         end else src_ready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
         if (src_valid && src_ready) begin
            chk("real", src_d_real, DW'(idx));
            chk("imag", src_d_imag, DW'(idx) ^ KEY);
            chk("sop", src_sop, idx == 0);
            chk("eop", src_eop, idx == n - 1);
            chk("dftpts_hold", src_dftpts, n);
            chk("inverse_hold", src_inverse, inv);
            fin = src_eop;
            idx++;
         end
      end
      chk("frame_complete", fin, 1);
      chk("beats", idx, n);
      @(negedge clk);
      chk("done_pulse", {done, busy, src_valid}, 3'b110);
      @(negedge clk);
      chk("done_clear", {done, busy}, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_dftpts = '0; start_inverse = 1'b0; src_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_zero("idle");
      run_frame(12, 0, 0, -1, -1, -1);
      run_frame(1, 1, 0, -1, -1, -1);
      run_frame(12, 0, 0, -1, 5, -1);
      @(negedge clk);
      start = 1'b1; start_dftpts = '0; start_inverse = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) begin
         chk("zero_len_ignored", {busy, done, src_valid, ram_rd_en}, 0);
         @(negedge clk);
      end
      run_frame(60, 0, 2, 10, -1, -1);
      maxc = 0;
      run_frame(1200, 0, 1, -1, -1, -1);
      chk("fifo_bound", maxc <= FIFO_DEP, 1);
      run_frame(96, 0, 0, -1, -1, 30);
      run_frame(5, 1, 0, -1, -1, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
